// File: rtl/icache_next_line_prefetcher.sv
`default_nettype none
// ============================================================================
//  Module   : icache_next_line_prefetcher
//  Brief    : Forwards I-cache line misses to the arbiter and prefetches the
//             next sequential 32-byte line into a one-line buffer.
//  Revision : 1.0  initial release
// ============================================================================
module icache_next_line_prefetcher #(
    parameter bit PF_ENABLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pf_flush,

    input  logic         pf_icache_read,
    input  logic [31:0]  pf_icache_address,
    output logic [255:0] pf_icache_rdata,
    output logic         pf_icache_resp,

    output logic         arb_icache_read,
    output logic [31:0]  arb_icache_address,
    input  logic [255:0] arb_icache_rdata,
    input  logic         arb_icache_resp,

    output logic         arb_pf_read,
    output logic [31:0]  arb_pf_address,
    input  logic [255:0] arb_pf_rdata,
    input  logic         arb_pf_resp,

    output logic [31:0]  pf_hit_count,
    output logic [31:0]  pf_miss_count
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_hit   = 2'd1;
    localparam logic [1:0]  c_st_fwd   = 2'd2;
    localparam logic [1:0]  c_st_pref  = 2'd3;
    localparam logic [26:0] c_line_max = 27'h7FF_FFFF;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;

    logic         r_buf_valid;
    logic [26:0]  r_buf_tag;
    logic [255:0] r_buf_data;
    logic [26:0]  r_pf_target;
    logic         r_discard;
    logic [31:0]  r_hit_count;
    logic [31:0]  r_miss_count;

    logic [26:0]  w_req_line;
    logic         w_buf_match;
    logic         w_fwd_done;
    logic         w_pf_done;
    logic         w_pf_discard;
    logic         w_pf_keep;
    logic         w_pf_match;
    logic         w_hit_now;
    logic [26:0]  w_succ_base;
    logic         w_pf_allowed;
    logic         w_unused_addr_lsbs;

    assign w_req_line         = pf_icache_address[31:5];
    assign w_unused_addr_lsbs = ^pf_icache_address[4:0];

    assign w_buf_match  = r_buf_valid && (r_buf_tag == w_req_line);
    assign w_fwd_done   = (r_state == c_st_fwd) && arb_icache_resp;
    assign w_pf_done    = (r_state == c_st_pref) && arb_pf_resp;

    // A flush poisons the in-flight prefetch, including one completing right now.
    assign w_pf_discard = r_discard || pf_flush;
    assign w_pf_keep    = w_pf_done && !w_pf_discard;
    assign w_pf_match   = w_pf_keep && pf_icache_read && (w_req_line == r_pf_target);
    assign w_hit_now    = (r_state == c_st_hit) || w_pf_match;

    // Line whose successor becomes the next prefetch target.
    always_comb begin
        w_succ_base = w_req_line;
        if (r_state == c_st_hit) begin
            w_succ_base = r_buf_tag;
        end else if (r_state == c_st_pref) begin
            w_succ_base = r_pf_target;
        end
    end

    assign w_pf_allowed = PF_ENABLE && (w_succ_base != c_line_max);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (pf_icache_read) begin
                    w_state_nxt = (w_buf_match && !pf_flush) ? c_st_hit : c_st_fwd;
                end
            end
            c_st_hit: begin
                w_state_nxt = w_pf_allowed ? c_st_pref : c_st_idle;
            end
            c_st_fwd: begin
                if (arb_icache_resp) begin
                    w_state_nxt = w_pf_allowed ? c_st_pref : c_st_idle;
                end
            end
            c_st_pref: begin
                if (arb_pf_resp) begin
                    w_state_nxt = (w_pf_match && w_pf_allowed) ? c_st_pref : c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pf_icache_rdata    = '0;
        pf_icache_resp     = 1'b0;
        arb_icache_read    = 1'b0;
        arb_icache_address = '0;
        arb_pf_read        = 1'b0;
        arb_pf_address     = '0;
        case (r_state)
            c_st_hit: begin
                pf_icache_resp  = 1'b1;
                pf_icache_rdata = r_buf_data;
            end
            c_st_fwd: begin
                arb_icache_read    = 1'b1;
                arb_icache_address = {w_req_line, 5'b0};
                pf_icache_rdata    = arb_icache_rdata;
                pf_icache_resp     = arb_icache_resp;
            end
            c_st_pref: begin
                arb_pf_read    = 1'b1;
                arb_pf_address = {r_pf_target, 5'b0};
                if (w_pf_match) begin
                    pf_icache_resp  = 1'b1;
                    pf_icache_rdata = arb_pf_rdata;
                end
            end
            default: begin
                pf_icache_resp = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prefetch target and discard tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_target <= '0;
            r_discard   <= 1'b0;
        end else begin
            if ((r_state == c_st_hit) || w_fwd_done || w_pf_match) begin
                r_pf_target <= w_succ_base + 27'd1;
            end
            if (w_pf_done) begin
                r_discard <= 1'b0;
            end else if (pf_flush && (r_state == c_st_pref)) begin
                r_discard <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else begin
            if (pf_flush) begin
                r_buf_valid <= 1'b0;
            end else if (w_pf_keep) begin
                r_buf_valid <= 1'b1;
            end
            if (w_pf_keep) begin
                r_buf_tag  <= r_pf_target;
                r_buf_data <= arb_pf_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_now) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fwd_done) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign pf_hit_count  = r_hit_count;
    assign pf_miss_count = r_miss_count;

endmodule
`default_nettype wire
